// File: rtl/imm_gen_pkg.sv
// Shared types for the pipelined RISC-V immediate generator: format codes and opcode constants.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_ILL = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // funct3 codes that turn OP-IMM into a shift with a shamt field
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SRX = 3'b101;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational instruction -> {immediate, format, illegal} decoder, zero latency.
// IMM_GEN_ZICSR_EN adds the CSR-immediate (FMT_Z) decode of the SYSTEM opcode.
module imm_decode_comb
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [5:0]  shamt;
  logic [31:0] imm_i_type;
  logic [31:0] imm_s_type;
  logic [31:0] imm_b_type;
  logic [31:0] imm_u_type;
  logic [31:0] imm_j_type;
  logic [31:0] imm32;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Shift amount is 6 bits only for RV64; bit 25 belongs to funct7 on RV32.
  assign shamt = (XLEN == 64) ? instr_i[25:20] : {1'b0, instr_i[24:20]};

  assign imm_i_type = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s_type = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b_type = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                       instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u_type = {instr_i[31:12], 12'b0};
  assign imm_j_type = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                       instr_i[20], instr_i[30:21], 1'b0};

  always_comb begin
    imm32     = '0;
    fmt_o     = FMT_R;
    illegal_o = 1'b0;
    case (opcode)
      OPC_OP: begin
        fmt_o = FMT_R;
      end
      OPC_OP_IMM: begin
        fmt_o = FMT_I;
        if (funct3 == F3_SLL || funct3 == F3_SRX) begin
          imm32 = {26'b0, shamt};
        end else begin
          imm32 = imm_i_type;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        fmt_o = FMT_I;
        imm32 = imm_i_type;
      end
      OPC_STORE: begin
        fmt_o = FMT_S;
        imm32 = imm_s_type;
      end
      OPC_BRANCH: begin
        fmt_o = FMT_B;
        imm32 = imm_b_type;
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt_o = FMT_U;
        imm32 = imm_u_type;
      end
      OPC_JAL: begin
        fmt_o = FMT_J;
        imm32 = imm_j_type;
      end
`ifdef IMM_GEN_ZICSR_EN
      OPC_SYSTEM: begin
        if (funct3 inside {3'b101, 3'b110, 3'b111}) begin
          fmt_o = FMT_Z;
          imm32 = {27'b0, instr_i[19:15]};
        end else begin
          fmt_o = FMT_I;
          imm32 = imm_i_type;
        end
      end
`endif
      default: begin
        fmt_o     = FMT_ILL;
        illegal_o = 1'b1;
      end
    endcase
  end

  // Zero-extended fields keep bit 31 clear, so one sign extension covers every format.
  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Two-stage valid/ready immediate generator: 2-cycle latency, 1/cycle, full back-pressure.
// Stage 1 holds the raw instruction, stage 2 the decoded result; the ready chain is combinational.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output imm_fmt_e         out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_instr_q, s1_instr_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic             out_valid_q,   out_valid_d;
  logic [XLEN-1:0]  out_imm_q,     out_imm_d;
  imm_fmt_e         out_fmt_q,     out_fmt_d;
  logic             out_illegal_q, out_illegal_d;
  logic [TAG_W-1:0] out_tag_q,     out_tag_d;

  logic             s2_load;
  logic             s1_load;
  logic [XLEN-1:0]  dec_imm;
  imm_fmt_e         dec_fmt;
  logic             dec_illegal;

  assign s2_load  = !out_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  imm_decode_comb #(
    .XLEN (XLEN)
  ) u_decode (
    .instr_i   (s1_instr_q),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_instr_d = s1_instr_q;
    s1_tag_d   = s1_tag_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_instr_d = in_instr;
        s1_tag_d   = in_tag;
      end
    end
  end

  // Payload only moves with a valid entry so a drained output keeps its last value.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_imm_d     = out_imm_q;
    out_fmt_d     = out_fmt_q;
    out_illegal_d = out_illegal_q;
    out_tag_d     = out_tag_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_imm_d     = dec_imm;
        out_fmt_d     = dec_fmt;
        out_illegal_d = dec_illegal;
        out_tag_d     = s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_instr_q <= s1_instr_d;
      s1_tag_q   <= s1_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      out_imm_q     <= '0;
      out_fmt_q     <= FMT_R;
      out_illegal_q <= 1'b0;
      out_tag_q     <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_imm_q     <= out_imm_d;
      out_fmt_q     <= out_fmt_d;
      out_illegal_q <= out_illegal_d;
      out_tag_q     <= out_tag_d;
    end
  end

  // Masked during reset so a consumer can never complete a handshake on a discarded entry.
  assign out_valid   = out_valid_q && !rst;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_illegal_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances run in lockstep on shared stimulus.
// Expectations for the SYSTEM opcode follow IMM_GEN_ZICSR_EN.
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_ready64;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_valid;
  logic        out_valid64;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [63:0] out_imm64;
  imm_fmt_e    out_fmt;
  imm_fmt_e    out_fmt64;
  logic        out_illegal;
  logic        out_illegal64;
  logic [7:0]  out_tag;
  logic [7:0]  out_tag64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal),
    .out_tag     (out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready64),
    .in_instr    (in_instr),
    .in_tag      (in_tag),
    .out_valid   (out_valid64),
    .out_ready   (out_ready),
    .out_imm     (out_imm64),
    .out_fmt     (out_fmt64),
    .out_illegal (out_illegal64),
    .out_tag     (out_tag64)
  );

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill;
    logic [7:0]  tag;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  // Output side: compare the head of the scoreboard every cycle it is presented, pop on transfer.
  always @(negedge clk) begin
    #2;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("stale_out_valid", 64'(out_valid), 64'd0);
      end else begin
        m_e = sb[0];
        chk("out_tag",       64'(out_tag),       64'(m_e.tag));
        chk("out_imm32",     64'(out_imm),       64'(m_e.imm32));
        chk("out_fmt32",     64'(out_fmt),       64'(m_e.fmt));
        chk("out_illegal32", 64'(out_illegal),   64'(m_e.ill));
        chk("out_valid64",   64'(out_valid64),   64'd1);
        chk("out_tag64",     64'(out_tag64),     64'(m_e.tag));
        chk("out_imm64",     out_imm64,          m_e.imm64);
        chk("out_fmt64",     64'(out_fmt64),     64'(m_e.fmt));
        chk("out_illegal64", 64'(out_illegal64), 64'(m_e.ill));
        if (out_ready) begin
          if (m_e.chk_lat) chk("latency", 64'(cyc - m_e.acc_cyc), 64'd2);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] tag, input logic [31:0] e32, input logic [63:0] e64,
                          input logic [2:0] fmt, input logic ill);
    exp_t e;
    e.imm32   = e32;
    e.imm64   = e64;
    e.fmt     = fmt;
    e.ill     = ill;
    e.tag     = tag;
    e.acc_cyc = cyc;
    e.chk_lat = lat_en;
    sb.push_back(e);
  endtask

  task automatic send(input logic [31:0] instr, input logic [7:0] tag, input logic [31:0] e32,
                      input logic [63:0] e64, input logic [2:0] fmt, input logic ill);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_tag   = tag;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    else push_exp(tag, e32, e64, fmt, ill);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    in_instr = 32'hDEAD_BEEF;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid",   64'(out_valid),   64'd0);
    chk("rst_out_imm",     64'(out_imm),     64'd0);
    chk("rst_out_fmt",     64'(out_fmt),     64'(FMT_R));
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    chk("rst_out_tag",     64'(out_tag),     64'd0);
    chk("rst_in_ready",    64'(in_ready),    64'd1);

    // Back-to-back decode of every format.
    send(32'hFFF00093, 8'hA5, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, FMT_I, 1'b0);
    send(32'hFE112E23, 8'h11, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, FMT_S, 1'b0);
    send(32'hFE000CE3, 8'h12, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, FMT_B, 1'b0);
    send(32'h001000EF, 8'h13, 32'h00000800, 64'h00000000_00000800, FMT_J, 1'b0);
    send(32'h800002B7, 8'h14, 32'h80000000, 64'hFFFFFFFF_80000000, FMT_U, 1'b0);
    send(32'h0000007F, 8'h15, 32'h0,        64'h0,                 FMT_ILL, 1'b1);
`ifdef IMM_GEN_ZICSR_EN
    send(32'h00105073, 8'h16, 32'h0,        64'h0,                 FMT_Z, 1'b0);
    send(32'h30029073, 8'h17, 32'h00000300, 64'h00000000_00000300, FMT_I, 1'b0);
`else
    send(32'h00105073, 8'h16, 32'h0,        64'h0,                 FMT_ILL, 1'b1);
    send(32'h30029073, 8'h17, 32'h0,        64'h0,                 FMT_ILL, 1'b1);
`endif
    send(32'h002081B3, 8'h18, 32'h0,        64'h0,                 FMT_R, 1'b0);
    send(32'h02109093, 8'h19, 32'h00000001, 64'h00000000_00000021, FMT_I, 1'b0);
    send(32'h40105093, 8'h1A, 32'h00000001, 64'h00000000_00000001, FMT_I, 1'b0);
    send(32'h7FF00093, 8'h1B, 32'h000007FF, 64'h00000000_000007FF, FMT_I, 1'b0);
    send(32'h00001117, 8'h1C, 32'h00001000, 64'h00000000_00001000, FMT_U, 1'b0);
    send(32'hFFC08067, 8'h1D, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, FMT_I, 1'b0);
    send(32'h00412083, 8'hFF, 32'h00000004, 64'h00000000_00000004, FMT_I, 1'b0);
    idle(4);

    // Stall: two entries fill the pipe, the third waits at the input.
    lat_en    = 1'b0;
    out_ready = 1'b0;
    send(32'h00100093, 8'd1, 32'd1, 64'd1, FMT_I, 1'b0);
    send(32'h00200093, 8'd2, 32'd2, 64'd2, FMT_I, 1'b0);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = 32'h00300093;
    in_tag   = 8'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    push_exp(8'd3, 32'd3, 64'd3, FMT_I, 1'b0);
    @(posedge clk);
    idle(4);
    chk("stall_drained", 64'(sb.size()), 64'd0);

    // Reset with two entries in flight.
    out_ready = 1'b0;
    send(32'h00500093, 8'h41, 32'd5, 64'd5, FMT_I, 1'b0);
    send(32'h00600093, 8'h42, 32'd6, 64'd6, FMT_I, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid),  64'd0);
    chk("midrst_in_ready",  64'(in_ready),   64'd1);
    chk("midrst_in_ready64", 64'(in_ready64), 64'd1);
    out_ready = 1'b1;
    idle(6);

    // Post-reset traffic resumes cleanly.
    lat_en = 1'b1;
    send(32'hFE112E23, 8'h77, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, FMT_S, 1'b0);
    idle(1);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("final_drain", 64'(sb.size()), 64'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
